mem_access_ctrl: RTL and testbench

- Memory-side stage directly downstream of the CPU control unit.
- Holds the MAR and MDR registers and turns the control unit's level Read/Write strobes into a single req/ack transaction on the synchronous RAM port.
- Returns read data into MDR, drives it onto the datapath bus, and reports busy/done/err so the sequencer can stall on slow memory.

---
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// RAM-side port of the memory access controller: one request/ack transaction at a time.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // mem_req stays high from issue until the cycle mem_ack is sampled or the wait times out;
  // mem_ack is a single-cycle pulse and mem_rdata is only meaningful while mem_ack is high.
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MAR/MDR holder that turns level Read/Write strobes into one RAM req/ack transaction,
// with busy/done/err status for the sequencer.
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARen,
  input  logic              MDRen,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state_o,
  output logic [DATA_W-1:0] dbg_mar_o,
  mem_access_ctrl_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              read_q, write_q;
  logic              rise_r, rise_w;

  assign rise_r = Read & ~read_q;
  assign rise_w = Write & ~write_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      read_q  <= Read;
      write_q <= Write;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Simultaneous Read/Write edges are rejected outright, bus loads included.
        if (rise_r && rise_w) begin
          err_d = 1'b1;
        end else begin
          if (MARen)          mar_d = bus_in;
          if (MDRen && !Read) mdr_d = bus_in;
          if (rise_r || rise_w) begin
            state_d = ISSUE;
            we_d    = rise_w;
            cnt_d   = '0;
          end
        end
      end
      ISSUE: begin
        if (mem.mem_ack) begin
          if (!we_q) mdr_d = mem.mem_rdata;
          state_d = COMPLETE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          if (!we_q) mdr_d = mem.mem_rdata;
          state_d = COMPLETE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is decoded from state so an asynchronous reset drops it immediately.
  assign mem.mem_req   = (state_q == ISSUE) || (state_q == WAIT);
  assign mem.mem_we    = we_q & mem.mem_req;
  assign mem.mem_addr  = mar_q[ADDR_W-1:0];
  assign mem.mem_wdata = mdr_q;

  assign mdr_out     = mdr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == COMPLETE);
  assign err         = err_q;
  assign dbg_state_o = state_q;
  assign dbg_mar_o   = mar_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized transactions,
// checked against transaction-level expectations (latency, pulse counts, register contents).
module tb_mem_access_ctrl;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clock;
  logic              reset;
  logic [DATA_W-1:0] bus_in;
  logic              MARen, MDRen, Read, Write;
  logic [DATA_W-1:0] mdr_out;
  logic              busy, done, err;
  logic [1:0]        dbg_state;
  logic [DATA_W-1:0] dbg_mar;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .MARen(MARen), .MDRen(MDRen),
    .Read(Read), .Write(Write), .mdr_out(mdr_out), .busy(busy), .done(done), .err(err),
    .dbg_state_o(dbg_state), .dbg_mar_o(dbg_mar), .mem(mem.master)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model: what MAR and MDR must contain after each operation.
  logic [DATA_W-1:0] m_mar, m_mdr;
  logic [DATA_W-1:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus_in = '0; MARen = 1'b0; MDRen = 1'b0; Read = 1'b0; Write = 1'b0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
  endtask

  task automatic load_mar(input logic [DATA_W-1:0] v);
    @(negedge clock); MARen = 1'b1; bus_in = v;
    @(negedge clock); MARen = 1'b0;
    m_mar = v;
  endtask

  task automatic load_mdr(input logic [DATA_W-1:0] v);
    @(negedge clock); MDRen = 1'b1; bus_in = v;
    @(negedge clock); MDRen = 1'b0;
    m_mdr = v;
  endtask

  // w = number of wait cycles before ack; w < 0 means the RAM never answers.
  task automatic run_txn(input bit is_write, input int w, input logic [DATA_W-1:0] rdata,
                         input bit noise, input bit ld_mar, input logic [DATA_W-1:0] mar_v);
    bit timeout;
    int n, req_n, done_n, done_at, err_n, err_at;
    logic [DATA_W-1:0] exp_mdr;
    timeout = (w < 0);
    n = timeout ? TIMEOUT + 4 : w + 4;
    req_n = 0; done_n = 0; done_at = -1; err_n = 0; err_at = -1;
    @(negedge clock);
    if (is_write) Write = 1'b1; else Read = 1'b1;
    if (ld_mar) begin MARen = 1'b1; bus_in = mar_v; m_mar = mar_v; end
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      if (mem.mem_req) begin
        req_n++;
        checks++;
        if (mem.mem_addr !== m_mar[ADDR_W-1:0]) begin
          errors++; $display("FAIL txn_addr cyc=%0d got=%h exp=%h", c, mem.mem_addr, m_mar[ADDR_W-1:0]);
        end
        checks++;
        if (mem.mem_we !== is_write) begin
          errors++; $display("FAIL txn_we cyc=%0d got=%b exp=%b", c, mem.mem_we, is_write);
        end
        if (is_write) begin
          checks++;
          if (mem.mem_wdata !== m_mdr) begin
            errors++; $display("FAIL txn_wdata cyc=%0d got=%h exp=%h", c, mem.mem_wdata, m_mdr);
          end
        end
      end
      if (done === 1'b1) begin done_n++; done_at = c; end
      if (err === 1'b1) begin err_n++; err_at = c; end
      mem.mem_ack   = !timeout && (c == w + 1);
      mem.mem_rdata = mem.mem_ack ? rdata : DATA_W'($urandom);
      if (noise && c <= 2) begin
        MARen = 1'b1; MDRen = 1'b1; bus_in = DATA_W'($urandom);
        if (is_write) Write = (c == 2); else Read = (c == 2);
      end else begin
        MARen = 1'b0; MDRen = 1'b0;
      end
    end
    mem.mem_ack = 1'b0; Read = 1'b0; Write = 1'b0; MARen = 1'b0; MDRen = 1'b0;
    if (!timeout && !is_write) m_mdr = rdata;
    exp_q.push_back(m_mdr);

    checks++;
    if (req_n !== (timeout ? TIMEOUT + 1 : w + 1)) begin
      errors++; $display("FAIL req_cycles got=%0d exp=%0d", req_n, timeout ? TIMEOUT + 1 : w + 1);
    end
    checks++;
    if (done_n !== (timeout ? 0 : 1)) begin
      errors++; $display("FAIL done_count got=%0d exp=%0d", done_n, timeout ? 0 : 1);
    end
    if (!timeout) begin
      checks++;
      if (done_at !== w + 2) begin
        errors++; $display("FAIL done_latency got=%0d exp=%0d", done_at, w + 2);
      end
    end
    checks++;
    if (err_n !== (timeout ? 1 : 0)) begin
      errors++; $display("FAIL err_count got=%0d exp=%0d", err_n, timeout ? 1 : 0);
    end
    if (timeout) begin
      checks++;
      if (err_at !== TIMEOUT + 2) begin
        errors++; $display("FAIL err_latency got=%0d exp=%0d", err_at, TIMEOUT + 2);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_after got=%b exp=0", busy);
    end
    exp_mdr = exp_q.pop_front();
    checks++;
    if (mdr_out !== exp_mdr) begin
      errors++; $display("FAIL mdr_after got=%h exp=%h", mdr_out, exp_mdr);
    end
    checks++;
    if (dbg_mar !== m_mar) begin
      errors++; $display("FAIL mar_after got=%h exp=%h", dbg_mar, m_mar);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({mem.mem_req, mem.mem_we, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mem.mem_req, mem.mem_we, busy, done, err});
    end
    checks++;
    if (mdr_out !== '0 || mem.mem_addr !== '0) begin
      errors++; $display("FAIL reset_regs got mdr=%h addr=%h exp=0", mdr_out, mem.mem_addr);
    end
    reset = 1'b0;
    m_mar = '0; m_mdr = '0;
  endtask

  task automatic test_reset_mid_wait();
    load_mar(32'h0000_0123);
    load_mdr(32'hCAFE_0001);
    @(negedge clock); Read = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (mem.mem_req !== 1'b1) begin
      errors++; $display("FAIL midwait_req got=%b exp=1", mem.mem_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem.mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got req=%b busy=%b exp=0", mem.mem_req, busy);
    end
    @(negedge clock);
    reset = 1'b0; Read = 1'b0;
    m_mar = '0; m_mdr = '0;
    @(negedge clock);
    checks++;
    if (mdr_out !== '0 || dbg_mar !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL after_reset got mdr=%h mar=%h busy=%b exp=0", mdr_out, dbg_mar, busy);
    end
  endtask

  task automatic test_read_basic();
    load_mar(32'h0000_0055);
    run_txn(1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
  endtask

  task automatic test_write_wait();
    load_mdr(32'h1234_5678);
    load_mar(32'h0000_01FF);
    run_txn(1'b1, 3, 32'h0BAD_F00D, 1'b0, 1'b0, '0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, -1, '0, 1'b0, 1'b0, '0);
    run_txn(1'b0, 0, 32'h7777_AAAA, 1'b0, 1'b0, '0);
  endtask

  task automatic test_conflict();
    load_mar(32'h0000_0042);
    @(negedge clock);
    Read = 1'b1; Write = 1'b1; MARen = 1'b1; bus_in = 32'h0000_0199;
    @(negedge clock);
    MARen = 1'b0;
    checks++;
    if (err !== 1'b1 || mem.mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL conflict got err=%b req=%b busy=%b exp=1,0,0", err, mem.mem_req, busy);
    end
    @(negedge clock);
    checks++;
    if (err !== 1'b0 || mem.mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL conflict_after got err=%b req=%b busy=%b exp=0,0,0", err, mem.mem_req, busy);
    end
    checks++;
    if (dbg_mar !== m_mar || mdr_out !== m_mdr) begin
      errors++; $display("FAIL conflict_regs got mar=%h mdr=%h exp mar=%h mdr=%h", dbg_mar, mdr_out, m_mar, m_mdr);
    end
    Read = 1'b0; Write = 1'b0;
  endtask

  task automatic test_busy_ignore();
    load_mar(32'h0000_0033);
    load_mdr(32'h5555_0000);
    run_txn(1'b0, 2, 32'h1111_2222, 1'b1, 1'b0, '0);
    run_txn(1'b1, 0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_mar_with_start();
    run_txn(1'b0, 1, 32'hFACE_0FF5, 1'b0, 1'b1, 32'hABCD_E1A5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1)) load_mar(DATA_W'($urandom));
      if ($urandom_range(0, 1)) load_mdr(DATA_W'($urandom));
      run_txn(1'(($urandom_range(0, 1))), int'($urandom_range(0, 5)), DATA_W'($urandom),
              1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 3) == 0)), DATA_W'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait();
    test_timeout();
    test_conflict();
    test_busy_ignore();
    test_mar_with_start();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
